// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per cycle, signed/unsigned with divide-by-zero flag
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Dbz,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_rem, r_dvs, r_q, r_r;
  logic             r_neg_q, r_neg_r, r_dbz;

  logic             w_accept, w_a_neg, w_b_neg, w_qbit, w_b_zero;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_nx, w_quo_nx;
  logic [WIDTH:0]   w_part;
  logic [WIDTH+1:0] w_diff;

  assign w_accept = in_valid && in_ready;
  assign w_b_zero = (B == '0);
  assign w_a_neg  = is_signed && A[WIDTH-1];
  assign w_b_neg  = is_signed && B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  // The extra top bit of the difference is its sign: set means "does not fit", so restore.
  assign w_part   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = {1'b0, w_part} - {2'b00, r_dvs};
  assign w_qbit   = ~w_diff[WIDTH+1];
  assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
  assign w_quo_nx = {r_dvd[WIDTH-2:0], w_qbit};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = (r_state == IDLE) ? (w_accept ? (w_b_zero ? DONE : CALC) : IDLE) :
             (r_state == CALC) ? ((r_cnt == '0) ? DONE : CALC) :
             (out_ready ? IDLE : DONE);
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == CALC);
    out_valid = (r_state == DONE);
  end

  // Datapath: capture magnitudes at accept, shift/subtract in CALC, sign fix-up on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_rem   <= '0;
      r_cnt   <= CW'(WIDTH - 1);
      r_dbz   <= w_b_zero;
      if (w_b_zero) begin
        r_q <= '1;
        r_r <= A;
      end
    end else if (r_state == CALC) begin
      r_dvd <= w_quo_nx;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_q <= r_neg_q ? -w_quo_nx : w_quo_nx;
        r_r <= r_neg_r ? -w_rem_nx : w_rem_nx;
      end
    end
  end

  assign Q   = r_q;
  assign R   = r_r;
  assign Dbz = r_dbz;
endmodule
